// File: rtl/larpix_pkg.sv
// Shared definitions for the LArPix configuration responder: packet layout,
// declare codes, magic number, register defaults, FSM states and reply builder.
package larpix_pkg;

    localparam int PKT_W      = 64;
    localparam int DECL_LSB   = 0;
    localparam int CHIP_LSB   = 2;
    localparam int ADDR_LSB   = 10;
    localparam int DATA_LSB   = 18;
    localparam int MAGIC_LSB  = 26;
    localparam int SPARE_LSB  = 58;
    localparam int MARKER_BIT = 62;
    localparam int PARITY_BIT = 63;

    localparam int          REGMAP_DEPTH   = 256;
    localparam logic [31:0] MAGIC_NUMBER   = 32'h8950_4E47;
    localparam logic [REGMAP_DEPTH*8-1:0] REGMAP_DEFAULT = '0;

    typedef enum logic [1:0] {
        PKT_DATA      = 2'd1,
        PKT_CFG_WRITE = 2'd2,
        PKT_CFG_READ  = 2'd3
    } pkt_decl_e;

    typedef enum logic [2:0] {
        IDLE,
        UNLOAD,
        CAPTURE,
        DECODE,
        EXECUTE,
        RESPOND
    } state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Replies always carry marker = 1 and odd parity over the whole packet.
    function automatic logic [PKT_W-1:0] build_reply(
        input logic [1:0]  decl,
        input logic [7:0]  chip,
        input logic [7:0]  addr,
        input logic [7:0]  data,
        input logic [31:0] magic,
        input logic [3:0]  spare
    );
        logic [PKT_W-1:0] p;
        p = {1'b0, 1'b1, spare, magic, data, addr, chip, decl};
        p[PARITY_BIT] = ~^p[MARKER_BIT:0];
        return p;
    endfunction

endpackage

// File: rtl/larpix_config_responder_if.sv
// UART-side packet handshake of the configuration responder.
// rx: rx_empty low means rx_data/parity_error hold a pending packet; a one-cycle uld_rx_data pops it.
// tx: a one-cycle ld_tx_data loads tx_data, issued only while tx_busy is low.
interface larpix_config_responder_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_empty;
    logic             parity_error;
    logic             uld_rx_data;
    logic [WIDTH-1:0] tx_data;
    logic             ld_tx_data;
    logic             tx_busy;

    modport master (
        output rx_data, rx_empty, parity_error, tx_busy,
        input  uld_rx_data, tx_data, ld_tx_data
    );

    modport slave (
        input  rx_data, rx_empty, parity_error, tx_busy,
        output uld_rx_data, tx_data, ld_tx_data
    );
endinterface

// File: rtl/larpix_regmap.sv
// 256x8 configuration register file: one synchronous write port, one
// combinational read port, and the whole map flattened onto an output bus.
module larpix_regmap
    import larpix_pkg::*;
#(
    parameter int REGNUM = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [7:0]          waddr,
    input  logic [7:0]          wdata,
    input  logic [7:0]          raddr,
    output logic [7:0]          rdata,
    output logic [REGNUM*8-1:0] regmap
);

    logic [7:0] mem_q [REGNUM];
    logic [7:0] mem_d [REGNUM];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REGNUM; i++) mem_q[i] <= REGMAP_DEFAULT[i*8 +: 8];
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

    for (genvar g = 0; g < REGNUM; g++) begin : g_flat
        assign regmap[g*8 +: 8] = mem_q[g];
    end

endmodule

// File: rtl/larpix_config_responder.sv
// Chip-side LArPix configuration responder: unloads UART packets, validates
// them, applies register writes and sends write/read replies back.
module larpix_config_responder
    import larpix_pkg::*;
#(
    parameter int         WIDTH     = 64,
    parameter int         REGNUM    = 256,
    parameter logic [7:0] GLOBAL_ID = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 chip_id,
    larpix_config_responder_if.slave   uart,
    output logic [REGNUM*8-1:0]        regmap,
    output logic [7:0]                 bad_parity_cnt,
    output logic [7:0]                 bad_packet_cnt,
    output state_e                     state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pkt_q, pkt_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] reply_q, reply_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             uld_q, uld_d;
    logic             ld_q, ld_d;
    logic [7:0]       bpar_q, bpar_d;
    logic [7:0]       bpkt_q, bpkt_d;

    logic [1:0]  decl;
    logic [7:0]  pkt_chip, pkt_addr, pkt_data, rd_data;
    logic [31:0] pkt_magic;
    logic [3:0]  pkt_spare;
    logic        parity_ok;
    logic        reg_we;

    assign decl      = pkt_q[DECL_LSB  +: 2];
    assign pkt_chip  = pkt_q[CHIP_LSB  +: 8];
    assign pkt_addr  = pkt_q[ADDR_LSB  +: 8];
    assign pkt_data  = pkt_q[DATA_LSB  +: 8];
    assign pkt_magic = pkt_q[MAGIC_LSB +: 32];
    assign pkt_spare = pkt_q[SPARE_LSB +: 4];
    assign parity_ok = (pkt_q[PARITY_BIT] == ~^pkt_q[MARKER_BIT:0]);

    larpix_regmap #(.REGNUM(REGNUM)) u_regmap (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (reg_we),
        .waddr   (pkt_addr),
        .wdata   (pkt_data),
        .raddr   (pkt_addr),
        .rdata   (rd_data),
        .regmap  (regmap)
    );

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        perr_d    = perr_q;
        reply_d   = reply_q;
        tx_data_d = tx_data_q;
        uld_d     = 1'b0;
        ld_d      = 1'b0;
        bpar_d    = bpar_q;
        bpkt_d    = bpkt_q;
        reg_we    = 1'b0;

        case (state_q)
            IDLE: if (!uart.rx_empty) state_d = UNLOAD;
            UNLOAD: begin
                uld_d   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                pkt_d   = uart.rx_data;
                perr_d  = uart.parity_error;
                state_d = DECODE;
            end
            DECODE: begin
                // Classification order matters: parity first, then declare, magic, chip ID.
                state_d = IDLE;
                if (perr_q || !parity_ok)                          bpar_d = sat_inc(bpar_q);
                else if (decl == 2'd0 || decl == PKT_DATA)         bpkt_d = sat_inc(bpkt_q);
                else if (pkt_magic != MAGIC_NUMBER)                bpkt_d = sat_inc(bpkt_q);
                else if (pkt_chip == chip_id || pkt_chip == GLOBAL_ID) state_d = EXECUTE;
            end
            EXECUTE: begin
                if (decl == PKT_CFG_WRITE) begin
                    reg_we  = 1'b1;
                    reply_d = build_reply(decl, chip_id, pkt_addr, pkt_data, pkt_magic, pkt_spare);
                end else begin
                    reply_d = build_reply(PKT_CFG_READ, chip_id, pkt_addr, rd_data, MAGIC_NUMBER, 4'h0);
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (!uart.tx_busy) begin
                    tx_data_d = reply_q;
                    ld_d      = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pkt_q     <= '0;
            perr_q    <= 1'b0;
            reply_q   <= '0;
            tx_data_q <= '0;
            uld_q     <= 1'b0;
            ld_q      <= 1'b0;
            bpar_q    <= '0;
            bpkt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            perr_q    <= perr_d;
            reply_q   <= reply_d;
            tx_data_q <= tx_data_d;
            uld_q     <= uld_d;
            ld_q      <= ld_d;
            bpar_q    <= bpar_d;
            bpkt_q    <= bpkt_d;
        end
    end

    assign uart.uld_rx_data = uld_q;
    assign uart.tx_data     = tx_data_q;
    assign uart.ld_tx_data  = ld_q;
    assign bad_parity_cnt   = bpar_q;
    assign bad_packet_cnt   = bpkt_q;
    assign state            = state_q;

endmodule

// File: tb/tb_larpix_config_responder.sv
// Randomized bench for larpix_config_responder: a FIFO receiver model, a reply
// scoreboard and a packet-level reference model of the register map and counters.
module tb_larpix_config_responder;
  import larpix_pkg::*;

  localparam logic [7:0]  CHIP  = 8'h10;
  localparam logic [31:0] MAGIC = 32'h8950_4E47;

  typedef struct {
    logic [63:0] pkt;
    logic        perr;
  } rx_item_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    chip_id;
  logic [2047:0] regmap;
  logic [7:0]    bad_parity_cnt, bad_packet_cnt;
  state_e        dut_state;

  larpix_config_responder_if #(.WIDTH(64)) uart_if ();

  larpix_config_responder #(.WIDTH(64), .REGNUM(256), .GLOBAL_ID(8'hFF)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chip_id        (chip_id),
    .uart           (uart_if),
    .regmap         (regmap),
    .bad_parity_cnt (bad_parity_cnt),
    .bad_packet_cnt (bad_packet_cnt),
    .state          (dut_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  rx_item_t    rx_q[$];
  bit          pop_next = 0;
  bit          rand_busy = 0;
  int          uld_cnt = 0;
  int          ld_cnt = 0;
  int          unexpected = 0;
  int          m_replies = 0;
  logic [7:0]  m_reg[256];
  logic [7:0]  m_bpar, m_bpkt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] make_pkt(input logic [1:0] d, input logic [7:0] c,
      input logic [7:0] a, input logic [7:0] v, input logic [31:0] m,
      input logic [3:0] s, input logic mk);
    logic [63:0] p;
    p = {1'b0, mk, s, m, v, a, c, d};
    p[63] = ($countones(p[62:0]) % 2 == 0);
    return p;
  endfunction

  function automatic int regmap_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (regmap[i*8 +: 8] !== m_reg[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
    m_bpar = 0;
    m_bpkt = 0;
    m_replies -= exp_q.size();
    exp_q.delete();
  endtask

  // Packet-level behaviour: classify, update map/counters, queue the expected reply.
  task automatic model_rx(input logic [63:0] p, input logic perr);
    logic [63:0] r;
    if (perr || ($countones(p) % 2 == 0)) begin
      if (m_bpar != 8'hFF) m_bpar++;
    end else if (p[1:0] < 2 || p[57:26] != MAGIC) begin
      if (m_bpkt != 8'hFF) m_bpkt++;
    end else if (p[9:2] == CHIP || p[9:2] == 8'hFF) begin
      if (p[1:0] == 2) begin
        m_reg[p[17:10]] = p[25:18];
        r = p;
        r[9:2] = CHIP;
        r[62] = 1'b1;
        r[63] = ($countones(r[62:0]) % 2 == 0);
      end else begin
        r = make_pkt(2'd3, CHIP, p[17:10], m_reg[p[17:10]], MAGIC, 4'h0, 1'b1);
      end
      exp_q.push_back(r);
      m_replies++;
    end
  endtask

  task automatic drive_rx();
    uart_if.rx_empty     = (rx_q.size() == 0);
    uart_if.rx_data      = (rx_q.size() != 0) ? rx_q[0].pkt : 64'h0;
    uart_if.parity_error = (rx_q.size() != 0) ? rx_q[0].perr : 1'b0;
  endtask

  task automatic push_pkt(input logic [63:0] p, input logic perr);
    rx_q.push_back('{pkt: p, perr: perr});
    model_rx(p, perr);
    drive_rx();
  endtask

  // Receiver pops one cycle after seeing the unload strobe; transmitter side feeds the scoreboard.
  always @(negedge clk) begin
    if (pop_next && rx_q.size() != 0) void'(rx_q.pop_front());
    pop_next = reset_n && uart_if.uld_rx_data;
    if (uart_if.uld_rx_data) uld_cnt++;
    if (uart_if.ld_tx_data) begin
      ld_cnt++;
      if (exp_q.size() == 0) unexpected++;
      else check("reply", uart_if.tx_data, exp_q.pop_front());
    end
    drive_rx();
    if (rand_busy) uart_if.tx_busy = ($urandom_range(0, 3) == 0);
  end

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (rx_q.size() == 0 && exp_q.size() == 0 && !pop_next && dut_state == IDLE) begin
        done = 1;
        break;
      end
    end
    check("drain", done, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_respond();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (dut_state == RESPOND) begin
        seen = 1;
        break;
      end
    end
    check("reach_respond", seen, 1);
  endtask

  initial begin
    int lat, ld0, uld0;
    logic [63:0] p;
    reset_n = 1'b0;
    chip_id = CHIP;
    uart_if.tx_busy = 1'b0;
    drive_rx();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_uld", uart_if.uld_rx_data, 0);
    check("rst_ld", uart_if.ld_tx_data, 0);
    check("rst_tx_data", uart_if.tx_data, 0);
    check("rst_bpar", bad_parity_cnt, 0);
    check("rst_bpkt", bad_packet_cnt, 0);
    check("rst_regmap_diffs", regmap_diffs(), 0);
    check("rst_state", dut_state, IDLE);
    reset_n = 1'b1;
    @(negedge clk); #1;

    // Directed write then read-back with latency measurement.
    push_pkt(make_pkt(2'd2, 8'h10, 8'h2A, 8'h5C, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_drain();
    check("wr_reg42", regmap[42*8 +: 8], 8'h5C);
    check("wr_reply_hdr", {uart_if.tx_data[62], uart_if.tx_data[25:0]}, {1'b1, 8'h5C, 8'h2A, 8'h10, 2'd2});
    check("wr_reply_parity", $countones(uart_if.tx_data) % 2, 1);

    push_pkt(make_pkt(2'd3, 8'h10, 8'h2A, 8'h00, MAGIC, 4'h0, 1'b0), 1'b0);
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (uart_if.ld_tx_data) break;
    end
    check("rd_latency", lat, 5);
    check("rd_reply_data", uart_if.tx_data[25:18], 8'h5C);
    check("rd_reply_magic", uart_if.tx_data[57:26], 32'h89504E47);
    check("rd_reply_decl", uart_if.tx_data[1:0], 2'd3);
    wait_drain();

    // Bad parity, bad magic, bad declare.
    ld0 = ld_cnt;
    p = make_pkt(2'd2, CHIP, 8'h01, 8'h11, MAGIC, 4'h0, 1'b0);
    p[63] = ~p[63];
    push_pkt(p, 1'b0);
    push_pkt(make_pkt(2'd2, CHIP, 8'h01, 8'h22, 32'h0, 4'h0, 1'b0), 1'b0);
    push_pkt(make_pkt(2'd1, CHIP, 8'h01, 8'h33, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_drain();
    check("bad_bpar", bad_parity_cnt, 1);
    check("bad_bpkt", bad_packet_cnt, 2);
    check("bad_no_reply", ld_cnt - ld0, 0);
    check("bad_regmap_diffs", regmap_diffs(), 0);

    // Foreign chip ignored, broadcast handled.
    ld0 = ld_cnt;
    push_pkt(make_pkt(2'd2, 8'h1F, 8'h03, 8'h77, MAGIC, 4'h0, 1'b0), 1'b0);
    push_pkt(make_pkt(2'd2, 8'hFF, 8'h03, 8'hA5, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_drain();
    check("bc_reg3", regmap[3*8 +: 8], 8'hA5);
    check("bc_reply_chip", uart_if.tx_data[9:2], 8'h10);
    check("bc_reply_count", ld_cnt - ld0, 1);
    check("bc_counts", {bad_parity_cnt, bad_packet_cnt}, {8'd1, 8'd2});

    // tx_busy stall with a second packet arriving during RESPOND.
    uart_if.tx_busy = 1'b1;
    push_pkt(make_pkt(2'd3, CHIP, 8'h2A, 8'h00, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_respond();
    @(negedge clk); #1;
    push_pkt(make_pkt(2'd2, CHIP, 8'h05, 8'hC3, MAGIC, 4'h0, 1'b0), 1'b0);
    ld0 = ld_cnt;
    uld0 = uld_cnt;
    repeat (50) @(negedge clk);
    #1;
    check("busy_no_ld", ld_cnt - ld0, 0);
    check("busy_no_uld", uld_cnt - uld0, 0);
    uart_if.tx_busy = 1'b0;
    @(posedge clk); #1;
    check("busy_release_ld", uart_if.ld_tx_data, 1);
    wait_drain();
    check("busy_reply_count", ld_cnt - ld0, 2);
    check("busy_reg5", regmap[5*8 +: 8], 8'hC3);

    // Reset during RESPOND discards the pending reply.
    uart_if.tx_busy = 1'b1;
    push_pkt(make_pkt(2'd3, CHIP, 8'h03, 8'h00, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_respond();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_ld", uart_if.ld_tx_data, 0);
    check("mid_rst_tx_data", uart_if.tx_data, 0);
    check("mid_rst_counts", {bad_parity_cnt, bad_packet_cnt}, {m_bpar, m_bpkt});
    check("mid_rst_regmap_diffs", regmap_diffs(), 0);
    ld0 = ld_cnt;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    uart_if.tx_busy = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mid_rst_discard", ld_cnt - ld0, 0);
    push_pkt(make_pkt(2'd2, CHIP, 8'h07, 8'h3C, MAGIC, 4'h0, 1'b0), 1'b0);
    wait_drain();
    check("post_rst_reg7", regmap[7*8 +: 8], 8'h3C);

    // Randomized traffic with a jittering tx_busy.
    rand_busy = 1;
    for (int n = 0; n < 80; n++) begin
      int kind, cs;
      logic [7:0] c;
      cs = $urandom_range(0, 5);
      c = (cs == 0) ? 8'hFF : (cs == 1) ? 8'h20 + 8'($urandom_range(0, 15)) : CHIP;
      kind = $urandom_range(0, 9);
      p = make_pkt((kind < 4) ? 2'd2 : 2'd3, c, 8'($urandom_range(0, 7)), 8'($urandom),
                   MAGIC, 4'($urandom), 1'($urandom));
      if (kind == 7) p[63] = ~p[63];
      if (kind == 9) begin
        if ($urandom_range(0, 1) == 0) p = make_pkt(2'($urandom_range(0, 1)), c, 8'h00, 8'h00, MAGIC, 4'h0, 1'b0);
        else p = make_pkt(2'd2, c, 8'h00, 8'h00, 32'($urandom), 4'h0, 1'b0);
      end
      push_pkt(p, kind == 8);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      #1;
    end
    wait_drain();
    rand_busy = 0;
    uart_if.tx_busy = 1'b0;
    wait_drain();
    check("rand_bpar", bad_parity_cnt, m_bpar);
    check("rand_bpkt", bad_packet_cnt, m_bpkt);
    check("rand_regmap_diffs", regmap_diffs(), 0);

    // Counter saturation.
    for (int n = 0; n < 260; n++) begin
      push_pkt(make_pkt(2'd2, CHIP, 8'h09, 8'h99, 32'h0, 4'h0, 1'b0), 1'b0);
      push_pkt(make_pkt(2'd2, CHIP, 8'h09, 8'h99, MAGIC, 4'h0, 1'b0), 1'b1);
    end
    wait_drain();
    check("sat_bpkt", bad_packet_cnt, 8'hFF);
    check("sat_bpar", bad_parity_cnt, 8'hFF);
    check("sat_regmap_diffs", regmap_diffs(), 0);

    check("unexpected_replies", unexpected, 0);
    check("reply_total", ld_cnt, m_replies);
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
